// File: rtl/wishbone_mem_arbiter.sv
// wishbone_mem_arbiter: shares one single-port Wishbone memory slave between the
// VexRiscv iBus and dBus masters. Round-robin arbitration, grant locked for the
// whole bus cycle, out-of-window accesses answered locally with ERR.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort cycles the slave never answers.
module wishbone_mem_arbiter #(
  parameter logic [29:0] MEM_BASE_WORD  = 30'h08000000,
  parameter int          MEM_SIZE_WORDS = 262144,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iBusWishbone_CYC,
  input  logic        iBusWishbone_STB,
  input  logic        iBusWishbone_WE,
  input  logic [29:0] iBusWishbone_ADR,
  input  logic [31:0] iBusWishbone_DAT_MOSI,
  input  logic [3:0]  iBusWishbone_SEL,
  output logic        iBusWishbone_ACK,
  output logic        iBusWishbone_ERR,
  output logic [31:0] iBusWishbone_DAT_MISO,
  input  logic        dBusWishbone_CYC,
  input  logic        dBusWishbone_STB,
  input  logic        dBusWishbone_WE,
  input  logic [29:0] dBusWishbone_ADR,
  input  logic [31:0] dBusWishbone_DAT_MOSI,
  input  logic [3:0]  dBusWishbone_SEL,
  output logic        dBusWishbone_ACK,
  output logic        dBusWishbone_ERR,
  output logic [31:0] dBusWishbone_DAT_MISO,
  output logic        memWishbone_CYC,
  output logic        memWishbone_STB,
  output logic        memWishbone_WE,
  output logic [29:0] memWishbone_ADR,
  output logic [31:0] memWishbone_DAT_MOSI,
  output logic [3:0]  memWishbone_SEL,
  input  logic        memWishbone_ACK,
  input  logic        memWishbone_ERR,
  input  logic [31:0] memWishbone_DAT_MISO
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t      state, state_n;
  logic        last_d;
  logic        own_cyc, own_stb, own_we, own_win;
  logic [29:0] own_adr;
  logic [31:0] own_dat;
  logic [3:0]  own_sel;
  logic        loc_err_q, loc_err_fire, resp_ok, own_ack, own_err;
  logic        blk, to_fire;

  // 31-bit compare so BASE+SIZE cannot wrap past the top of the address space
  function automatic logic in_window(input logic [29:0] adr);
    logic [30:0] a, lo, hi;
    a  = {1'b0, adr};
    lo = {1'b0, MEM_BASE_WORD};
    hi = lo + 31'(MEM_SIZE_WORDS);
    return (a >= lo) && (a < hi);
  endfunction

  // state register, round-robin history and local-ERR pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      loc_err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == GNT_I && state != GNT_I) last_d <= 1'b0;
      if (state_n == GNT_D && state != GNT_D) last_d <= 1'b1;
      loc_err_q <= own_cyc && own_stb && !own_win && !loc_err_q && !blk;
    end
  end

  // next-state arbitration: tie goes to the master that was not granted last
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (iBusWishbone_CYC && dBusWishbone_CYC) state_n = last_d ? GNT_I : GNT_D;
        else if (iBusWishbone_CYC)                state_n = GNT_I;
        else if (dBusWishbone_CYC)                state_n = GNT_D;
      end
      GNT_I: if (!iBusWishbone_CYC) state_n = dBusWishbone_CYC ? GNT_D : IDLE;
      GNT_D: if (!dBusWishbone_CYC) state_n = iBusWishbone_CYC ? GNT_I : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // select the owner's request; everything reads as 0 while idle
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    if (state == GNT_I) begin
      own_cyc = iBusWishbone_CYC;
      own_stb = iBusWishbone_STB;
      own_we  = iBusWishbone_WE;
      own_adr = iBusWishbone_ADR;
      own_dat = iBusWishbone_DAT_MOSI;
      own_sel = iBusWishbone_SEL;
    end else if (state == GNT_D) begin
      own_cyc = dBusWishbone_CYC;
      own_stb = dBusWishbone_STB;
      own_we  = dBusWishbone_WE;
      own_adr = dBusWishbone_ADR;
      own_dat = dBusWishbone_DAT_MOSI;
      own_sel = dBusWishbone_SEL;
    end
  end

  assign own_win      = in_window(own_adr);
  // local ERR only reaches a master that is still presenting the access
  assign loc_err_fire = loc_err_q && own_cyc && own_stb;
  assign resp_ok      = !loc_err_q && !blk && !to_fire;
  assign own_ack      = memWishbone_ACK && resp_ok;
  assign own_err      = (memWishbone_ERR && resp_ok) || loc_err_fire || to_fire;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_blk;

  assign to_fire = own_cyc && own_stb && !to_blk && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign blk     = to_blk;

  // watchdog: count unanswered strobe cycles, then keep CYC low until the owner lets go
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      to_blk <= 1'b0;
    end else begin
      if (state_n != state || !own_cyc || !own_stb || memWishbone_ACK || memWishbone_ERR ||
          to_blk || to_fire || loc_err_fire)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      if (state_n != state) to_blk <= 1'b0;
      else if (to_fire)     to_blk <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign blk     = 1'b0;
`endif

  assign memWishbone_CYC      = own_cyc && !blk && !to_fire;
  assign memWishbone_STB      = own_cyc && own_stb && own_win && !blk && !to_fire;
  assign memWishbone_WE       = own_we;
  assign memWishbone_ADR      = own_adr;
  assign memWishbone_DAT_MOSI = own_dat;
  assign memWishbone_SEL      = own_sel;

  assign iBusWishbone_ACK      = (state == GNT_I) && own_ack;
  assign iBusWishbone_ERR      = (state == GNT_I) && own_err;
  assign dBusWishbone_ACK      = (state == GNT_D) && own_ack;
  assign dBusWishbone_ERR      = (state == GNT_D) && own_err;
  assign iBusWishbone_DAT_MISO = reset_n ? memWishbone_DAT_MISO : '0;
  assign dBusWishbone_DAT_MISO = reset_n ? memWishbone_DAT_MISO : '0;

endmodule

// File: tb/tb_wishbone_mem_arbiter.sv
// Directed bench for wishbone_mem_arbiter (default build, watchdog disabled).
module tb_wishbone_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_cyc, i_stb, i_we, i_ack, i_err;
  logic [29:0] i_adr;
  logic [31:0] i_wdat, i_rdat;
  logic [3:0]  i_sel;
  logic        d_cyc, d_stb, d_we, d_ack, d_err;
  logic [29:0] d_adr;
  logic [31:0] d_wdat, d_rdat;
  logic [3:0]  d_sel;
  logic        mem_cyc, mem_stb, mem_we, mem_ack, mem_err;
  logic [29:0] mem_adr;
  logic [31:0] mem_wdat, mem_rdat;
  logic [3:0]  mem_sel;
  logic        slave_ack_en, slave_err_en;
  int          checks = 0;
  int          errors = 0;
  int          hang_resp, hang_drop;
  logic        exp_d;

  always #5 clk = ~clk;

  // zero-wait slave: answers every strobe in the same cycle, data derived from address
  assign mem_ack  = slave_ack_en & mem_stb;
  assign mem_err  = slave_err_en & mem_stb;
  assign mem_rdat = {2'b00, mem_adr} ^ 32'hA5A50000;

  wishbone_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .iBusWishbone_CYC(i_cyc), .iBusWishbone_STB(i_stb), .iBusWishbone_WE(i_we),
    .iBusWishbone_ADR(i_adr), .iBusWishbone_DAT_MOSI(i_wdat), .iBusWishbone_SEL(i_sel),
    .iBusWishbone_ACK(i_ack), .iBusWishbone_ERR(i_err), .iBusWishbone_DAT_MISO(i_rdat),
    .dBusWishbone_CYC(d_cyc), .dBusWishbone_STB(d_stb), .dBusWishbone_WE(d_we),
    .dBusWishbone_ADR(d_adr), .dBusWishbone_DAT_MOSI(d_wdat), .dBusWishbone_SEL(d_sel),
    .dBusWishbone_ACK(d_ack), .dBusWishbone_ERR(d_err), .dBusWishbone_DAT_MISO(d_rdat),
    .memWishbone_CYC(mem_cyc), .memWishbone_STB(mem_stb), .memWishbone_WE(mem_we),
    .memWishbone_ADR(mem_adr), .memWishbone_DAT_MOSI(mem_wdat), .memWishbone_SEL(mem_sel),
    .memWishbone_ACK(mem_ack), .memWishbone_ERR(mem_err), .memWishbone_DAT_MISO(mem_rdat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    slave_ack_en = 1'b1; slave_err_en = 1'b0;
    reset_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 30'h08000010; i_wdat = 32'h11110000; i_sel = 4'hF;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 30'h08000010; d_wdat = 32'hD00D0001; d_sel = 4'h3;

    // reset with both masters requesting
    repeat (3) tick();
    chk("rst_mem_cyc", 32'(mem_cyc), 0);
    chk("rst_mem_stb", 32'(mem_stb), 0);
    chk("rst_mem_adr", 32'(mem_adr), 0);
    chk("rst_mem_sel", 32'(mem_sel), 0);
    chk("rst_mem_we",  32'(mem_we), 0);
    chk("rst_i_ackerr", {30'd0, i_ack, i_err}, 0);
    chk("rst_d_ackerr", {30'd0, d_ack, d_err}, 0);

    // release: tie at 0x08000010, dBus wins
    reset_n = 1'b1;
    #1;
    chk("tie_idle_cyc", 32'(mem_cyc), 0);
    tick();
    chk("tie_d_sel",   32'(mem_sel), 32'h3);
    chk("tie_d_we",    32'(mem_we), 1);
    chk("tie_d_wdat",  mem_wdat, 32'hD00D0001);
    chk("tie_d_ack",   32'(d_ack), 1);
    chk("tie_i_ack",   32'(i_ack), 0);
    chk("tie_d_rdat",  d_rdat, 32'hADA50010);
    chk("tie_i_rdat",  i_rdat, 32'hADA50010);
    d_cyc = 1'b0; d_stb = 1'b0;
    #1;
    chk("tie_i_wait_ack", 32'(i_ack), 0);
    chk("tie_drop_cyc", 32'(mem_cyc), 0);
    tick();
    chk("tie_i_sel", 32'(mem_sel), 32'hF);
    chk("tie_i_ack2", 32'(i_ack), 1);
    chk("tie_d_ack2", 32'(d_ack), 0);
    i_cyc = 1'b0; i_stb = 1'b0;
    tick();
    chk("tie_back_idle", 32'(mem_cyc), 0);

    // lock: 3 back-to-back dBus strobes while iBus waits
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = 30'h08000100;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 30'h08000200;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lock_d_ack", 32'(d_ack), 1);
      chk("lock_adr",   32'(mem_adr), 32'h08000100 + 32'(k));
      chk("lock_i_ack", 32'(i_ack), 0);
      d_adr = d_adr + 30'd1;
    end
    d_cyc = 1'b0; d_stb = 1'b0;
    #1;
    chk("lock_i_still_wait", 32'(i_ack), 0);
    tick();
    chk("lock_i_ack", 32'(i_ack), 1);
    chk("lock_i_adr", 32'(mem_adr), 32'h08000200);
    i_cyc = 1'b0; i_stb = 1'b0;
    tick();

    // window: address 0 is answered locally
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 30'h00000000;
    tick();
    chk("win0_mem_cyc", 32'(mem_cyc), 1);
    chk("win0_mem_stb", 32'(mem_stb), 0);
    chk("win0_err_early", 32'(i_err), 0);
    chk("win0_ack", 32'(i_ack), 0);
    tick();
    chk("win0_err", 32'(i_err), 1);
    tick();
    chk("win0_err_1cyc", 32'(i_err), 0);
    i_adr = 30'h0803FFFF;
    #1;
    chk("win_top_stb", 32'(mem_stb), 1);
    chk("win_top_ack", 32'(i_ack), 1);
    chk("win_top_err", 32'(i_err), 0);
    chk("win_top_adr", 32'(mem_adr), 32'h0803FFFF);
    i_adr = 30'h08040000;
    #1;
    chk("win_end_stb", 32'(mem_stb), 0);
    chk("win_end_ack", 32'(i_ack), 0);
    tick();
    chk("win_end_err", 32'(i_err), 1);
    i_stb = 1'b0;
    #1;
    chk("win_end_err_gone", 32'(i_err), 0);
    tick();
    i_stb = 1'b1; i_adr = 30'h07FFFFFF;
    #1;
    chk("win_below_stb", 32'(mem_stb), 0);
    i_stb = 1'b0;
    tick();
    chk("win_suppressed", 32'(i_err), 0);
    i_cyc = 1'b0;
    tick();

    // starvation: each master drops CYC for one cycle after its ACK
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 30'h08000300;
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = 30'h08000400;
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("starve_d_ack", 32'(d_ack), 32'(exp_d));
      chk("starve_i_ack", 32'(i_ack), 32'(!exp_d));
      d_cyc = !exp_d; d_stb = !exp_d;
      i_cyc = exp_d;  i_stb = exp_d;
      exp_d = !exp_d;
    end
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    tick();

    // slave ERR routed to the owner only
    slave_ack_en = 1'b0; slave_err_en = 1'b1;
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = 30'h08000500;
    tick();
    chk("serr_d_err", 32'(d_err), 1);
    chk("serr_d_ack", 32'(d_ack), 0);
    chk("serr_i_err", 32'(i_err), 0);
    slave_err_en = 1'b0;
    d_cyc = 1'b0; d_stb = 1'b0;
    tick();

    // hung slave: without the watchdog the owner waits
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 30'h08000600;
    tick();
    hang_resp = 0; hang_drop = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (i_ack || i_err) hang_resp++;
      if (!mem_cyc || !mem_stb) hang_drop++;
    end
    chk("hang_no_resp", 32'(hang_resp), 0);
    chk("hang_bus_held", 32'(hang_drop), 0);
    slave_ack_en = 1'b1;
    #1;
    chk("hang_release_ack", 32'(i_ack), 1);
    i_cyc = 1'b0; i_stb = 1'b0;
    tick();

    // reset mid-transfer, then dBus again wins the first tie
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = 30'h08000700;
    tick();
    chk("mid_d_ack", 32'(d_ack), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(mem_cyc), 0);
    chk("mid_rst_adr", 32'(mem_adr), 0);
    chk("mid_rst_ack", 32'(d_ack), 0);
    tick();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 30'h08000800;
    reset_n = 1'b1;
    tick();
    chk("post_rst_grant_d", 32'(mem_sel), 32'h3);
    chk("post_rst_i_ack", 32'(i_ack), 0);
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
